// File: rtl/xor4_parity_sched.sv
// xor4_parity_sched
//   Round-robin scheduler that shares one combinational XOR4 parity core
//   among N_REQ requesters. A requester is granted for a whole frame of
//   4-bit nibbles. The running parity is accumulated, and a one-cycle result
//   strobe tagged with the owner ID is returned.
//
// Ports
//   i_clk    : clock, all state changes on the rising edge
//   i_rst_n  : synchronous active-low reset
//   i_req    : per-requester request (held until granted)
//   i_data   : nibble of requester k on [4k+3:4k], MSB..LSB = a,b,c,d
//   i_last   : per-requester last-nibble marker
//   o_gnt    : combinational one-hot (or zero) grant
//   o_vld    : one-cycle result strobe
//   o_f      : frame parity, registered, holds until the next strobe
//   o_id     : owner of the completed frame, registered
//   o_busy   : high while a multi-nibble frame is locked
//   o_abort  : one-cycle strobe when a locked frame times out
//
// Optional feature
//   XOR4_SCHED_TIMEOUT_EN : when defined, a 4-bit idle counter abandons a
//   locked frame after 16 consecutive LOCK cycles without an owner transfer.
//   When it is undefined, LOCK persists until i_last and o_abort is tied 0.

module xor4 (
    input  logic a,
    input  logic b,
    input  logic c,
    input  logic d,
    output logic f
);
    assign f = a ^ b ^ c ^ d;
endmodule

module xor4_parity_sched #(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic [N_REQ-1:0]     i_req,
    input  logic [4*N_REQ-1:0]   i_data,
    input  logic [N_REQ-1:0]     i_last,
    output logic [N_REQ-1:0]     o_gnt,
    output logic                 o_vld,
    output logic                 o_f,
    output logic [ID_W-1:0]      o_id,
    output logic                 o_busy,
    output logic                 o_abort
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] LOCK = 1'b1;

    logic [0:0]         state;
    logic [ID_W-1:0]    owner;
    logic [ID_W-1:0]    ptr;
    logic               acc;

    logic [2*N_REQ-1:0] dbl;
    logic [N_REQ-1:0]   rot;
    logic [ID_W-1:0]    off;
    logic               found;
    logic [ID_W-1:0]    gid;
    logic [3:0]         nib;
    logic               last;
    logic               xfer;
    logic               par;

    function automatic logic [ID_W-1:0] next_id(input logic [ID_W-1:0] id);
        return ID_W'((32'(id) + 32'd1) % N_REQ);
    endfunction

    // Rotating a doubled copy of i_req right by ptr puts the highest-priority
    // requester at bit 0, so a plain lowest-set-bit search gives the
    // round-robin choice as an offset from ptr.
    always_comb begin
        dbl   = {i_req, i_req};
        rot   = N_REQ'(dbl >> ptr);
        found = 1'b0;
        off   = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (!found && rot[i]) begin
                found = 1'b1;
                off   = ID_W'(i);
            end
        end
        if (state == LOCK)
            gid = owner;
        else
            gid = ID_W'((32'(ptr) + 32'(off)) % N_REQ);

        o_gnt = '0;
        if (i_rst_n) begin
            if (state == LOCK)
                o_gnt[owner] = i_req[owner];
            else if (found)
                o_gnt[gid] = 1'b1;
        end
    end

    // Grant is a subset of request, so any grant bit is a transfer.
    always_comb begin
        nib  = '0;
        last = 1'b0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            if (o_gnt[k]) begin
                nib  = i_data[4*k +: 4];
                last = i_last[k];
            end
        end
        xfer = |o_gnt;
    end

    xor4 u_xor4 (
        .a (nib[3]),
        .b (nib[2]),
        .c (nib[1]),
        .d (nib[0]),
        .f (par)
    );

    assign o_busy = i_rst_n && (state == LOCK);

`ifdef XOR4_SCHED_TIMEOUT_EN
    logic [3:0] idle_cnt;
    logic       abort;
    assign o_abort = abort;
`else
    assign o_abort = 1'b0;
`endif

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state <= IDLE;
            owner <= '0;
            ptr   <= '0;
            acc   <= 1'b0;
            o_vld <= 1'b0;
            o_f   <= 1'b0;
            o_id  <= '0;
`ifdef XOR4_SCHED_TIMEOUT_EN
            idle_cnt <= '0;
            abort    <= 1'b0;
`endif
        end else begin
            o_vld <= 1'b0;
`ifdef XOR4_SCHED_TIMEOUT_EN
            abort <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (xfer) begin
                        if (last) begin
                            o_vld <= 1'b1;
                            o_f   <= par;
                            o_id  <= gid;
                            ptr   <= next_id(gid);
                        end else begin
                            acc   <= par;
                            owner <= gid;
                            state <= LOCK;
`ifdef XOR4_SCHED_TIMEOUT_EN
                            idle_cnt <= '0;
`endif
                        end
                    end
                end
                default: begin
                    if (xfer) begin
                        acc <= acc ^ par;
`ifdef XOR4_SCHED_TIMEOUT_EN
                        idle_cnt <= '0;
`endif
                        if (last) begin
                            o_vld <= 1'b1;
                            o_f   <= acc ^ par;
                            o_id  <= owner;
                            ptr   <= next_id(owner);
                            state <= IDLE;
                        end
                    end
`ifdef XOR4_SCHED_TIMEOUT_EN
                    // 16th consecutive stalled LOCK cycle: drop the frame.
                    else if (idle_cnt == 4'd15) begin
                        idle_cnt <= '0;
                        abort    <= 1'b1;
                        ptr      <= next_id(owner);
                        state    <= IDLE;
                    end else begin
                        idle_cnt <= idle_cnt + 4'd1;
                    end
`endif
                end
            endcase
        end
    end

endmodule

// File: doc/xor4_parity_sched.md
# xor4_parity_sched

Round-robin scheduler sharing one XOR4 parity datapath among `N_REQ` requesters. Each requester submits a frame of one or more 4-bit nibbles; the block grants the datapath to one requester at a time, locks it for the whole frame, and accumulates the running XOR4 parity. It returns a one-cycle result strobe tagged with the requester ID. It sits between requesting client logic and the XOR4 component, which is instantiated internally as the combinational parity core.

## Interface

**Parameters**
- `N_REQ`, default 4: number of requesters, legal range 2..8.
- `ID_W`, default 2: requester ID width; must equal ceil(log2(`N_REQ`)).

**Ports**
- `i_clk` input 1: single clock; all state changes on the rising edge.
- `i_rst_n` input 1: reset, synchronous and active-low.
- `i_req` input `N_REQ`: per-requester request; the requester holds it high, with data and last stable, until granted.
- `i_data` input 4*`N_REQ`: nibble of requester k on bits [4k+3:4k]; bit order a,b,c,d = MSB..LSB into XOR4.
- `i_last` input `N_REQ`: marks the final nibble of the frame for requester k.
- `o_gnt` output `N_REQ`: one-hot or zero, combinational. A transfer occurs in any cycle with `i_req[k] & o_gnt[k]`.
- `o_vld` output 1: one-cycle result strobe.
- `o_f` output 1: frame parity (XOR of all nibble bits), valid when `o_vld` is high.
- `o_id` output `ID_W`: requester that owned the completed frame.
- `o_busy` output 1: high while a multi-nibble frame is locked.
- `o_abort` output 1: one-cycle strobe when a frame is abandoned by timeout; tied 0 when the timeout feature is not compiled in.

## Operation

- State machine with two states, IDLE and LOCK. Registers: `owner`, `acc` (1 bit), `ptr` (round-robin start, `ID_W` bits).
- **IDLE**
  - Search `i_req` from `ptr` upward, wrapping modulo `N_REQ`. Grant the first set bit; grant none if all are clear.
  - On a transfer with `i_last=1`: result = XOR4(nibble); stay in IDLE; `ptr` <= k+1 mod `N_REQ`.
  - On a transfer with `i_last=0`: `acc` <= XOR4(nibble); `owner` <= k; go to LOCK.
- **LOCK**
  - Only `o_gnt[owner]` may be high, and it equals `i_req[owner]`. All other requesters wait, whatever their priority.
  - On a transfer: `acc` <= `acc` ^ XOR4(nibble).
  - If `i_last=1`: the result is that accumulated value; go to IDLE; `ptr` <= owner+1 mod `N_REQ`.
- `ptr` changes only on frame completion or abort, never on individual nibbles.
- `i_last` and data of ungranted requesters are ignored.
- **Reset** (`i_rst_n=0` at a clock edge):
  - State <= IDLE; `acc`, `owner`, `ptr` <= 0.
  - `o_vld`, `o_f`, `o_id`, `o_abort` <= 0.
  - `o_gnt` forced to 0 while reset is asserted; `o_busy` = 0.
  - Any partial frame is discarded with no result.

## Timing

- Grant is combinational in the request cycle: zero-cycle acknowledge.
- Result latency: a transfer with `i_last` in cycle t gives `o_vld=1` in cycle t+1, for exactly one cycle. `o_f` and `o_id` are registered and hold until the next strobe.
- Throughput: one nibble per cycle. A new frame (any requester) may be granted in cycle t+1 after completion in cycle t.
- `o_busy` is high from the cycle after a non-last transfer through the cycle containing the last transfer.
- Owner gaps (`i_req[owner]=0` in LOCK) stall the frame without limit unless the timeout feature is enabled.

## Configuration

- Macro: `XOR4_SCHED_TIMEOUT_EN`.
- **Defined**
  - A 4-bit idle counter runs in LOCK and clears on every owner transfer.
  - After 16 consecutive LOCK cycles with no transfer, the frame is abandoned: `o_abort`=1 for one cycle on the next cycle, no `o_vld`, state <= IDLE, `ptr` <= owner+1 mod `N_REQ`.
  - The counter resets to 0 under reset.
- **Undefined**: no counter; LOCK persists until `i_last`; `o_abort` is constant 0.

## Test plan

- **Reset:** hold `i_rst_n=0` for 3 cycles with `i_req=4'b1111` -> `o_gnt=0`, `o_vld=0`, `o_f=0`, `o_id=0`, `o_busy=0`, `o_abort=0` throughout.
- **Single-nibble frame:** `i_req[0]=1`, nibble `4'b1011`, last=1 -> `o_gnt=4'b0001` same cycle; next cycle `o_vld=1`, `o_f=1`, `o_id=0`.
- **Multi-nibble lock:** requester 2 sends `4'b1111`, `4'b0001`, `4'b0110`(last) in consecutive cycles while `i_req[1]=1` -> only `o_gnt[2]`; `o_vld` with `o_f=1`, `o_id=2`; requester 1 granted in the cycle after the last transfer.
- **Round-robin fairness:** all four requesters continuously request single-nibble frames -> grants 0,1,2,3,0,1 in consecutive cycles, one `o_vld` per cycle with matching `o_id`.
- **Reset mid-frame:**
  - Stimulus: requester 3 sends a non-last nibble `4'b0001`, then `i_rst_n=0` for 1 cycle, then requester 3 sends `4'b0011`(last).
  - Required: no `o_vld` for the aborted frame; the new result is `o_f=0`, `o_id=3`; requester 0 has priority first after reset.
- **Timeout (`XOR4_SCHED_TIMEOUT_EN` defined):**
  - Stimulus: requester 1 sends a non-last nibble, then drops `i_req` for 16 cycles.
  - Required: `o_abort=1` for one cycle, `o_busy=0`, no `o_vld`, next grant search starts at requester 2.
  - Without the macro, the same stimulus keeps `o_busy=1` indefinitely.
